// File: rtl/cl_conveyer_pkg.sv
// Shared definitions for the conveyer tap.
//   cnt_width()  : bits needed for a counter that spans 0..max_val inclusive
//   ERR_OVERFLOW : value latched into the sticky overflow flag
package cl_conveyer_pkg;

  localparam logic ERR_OVERFLOW = 1'b1;

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/cl_conveyer_tap_fifo.sv
// First-word-fall-through result FIFO with an occupancy count.
//   clock_i/reset_i : clock, synchronous active-high reset (discards contents)
//   i_wr/i_wr_data  : write strobe and data; ignored when full unless a read
//                     happens in the same cycle
//   i_rd            : pop the head entry (ignored when empty)
//   o_rd_data       : head entry, valid whenever o_empty is low
//   o_empty         : no entries held
//   o_count         : number of entries held
module cl_conveyer_tap_fifo
  import cl_conveyer_pkg::*;
#(
  parameter type         T_RES = logic [7:0],
  parameter int unsigned DEPTH = 2
) (
  input  logic                          clock_i,
  input  logic                          reset_i,
  input  logic                          i_wr,
  input  logic [$bits(T_RES)-1:0]       i_wr_data,
  input  logic                          i_rd,
  output logic [$bits(T_RES)-1:0]       o_rd_data,
  output logic                          o_empty,
  output logic [cnt_width(DEPTH)-1:0]   o_count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = cnt_width(DEPTH);
  localparam int unsigned DW = $bits(T_RES);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);

  logic [DW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_rd;
  logic          w_wr;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == LAST_C) ? '0 : p + 1'b1;
  endfunction

  assign w_rd = i_rd && (r_count != '0);
  // A read in the same cycle frees the slot, so a write into a full FIFO is
  // still accepted.
  assign w_wr = i_wr && ((r_count != DEPTH_C) || w_rd);

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= ptr_next(r_wr_ptr);
      if (w_rd) r_rd_ptr <= ptr_next(r_rd_ptr);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clock_i) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
  end

  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;

endmodule

// File: rtl/cl_conveyer_tap.sv
// Worker-side end of a conveyer chain: takes jobs from the last conveyer
// stage, hands them to one PE, and queues the PE results towards the result
// conveyer. The PE result port has no backpressure, so a job is only issued
// while a FIFO slot for its result is guaranteed (credit counter).
//   clock_i, reset_i                          : clock, sync active-high reset
//   in_job_tdata/tvalid/tready                : job stream in
//   pe_job_data/valid/ready                   : job handoff to the PE
//   pe_res_data/valid                         : PE result strobe (no ready)
//   out_res_tdata/tvalid/tready               : result stream out
//   outstanding_o                             : jobs issued, result not yet out
//   jobs_done_o                               : results delivered (wraps)
//   overflow_o                                : sticky, result hit a full FIFO
module cl_conveyer_tap
  import cl_conveyer_pkg::*;
#(
  parameter type         T_JOB           = logic [7:0],
  parameter type         T_RES           = logic [7:0],
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned REG_VERSION     = 1
) (
  input  logic                                  clock_i,
  input  logic                                  reset_i,
  input  logic [$bits(T_JOB)-1:0]               in_job_tdata,
  input  logic                                  in_job_tvalid,
  output logic                                  in_job_tready,
  output logic [$bits(T_JOB)-1:0]               pe_job_data,
  output logic                                  pe_job_valid,
  input  logic                                  pe_job_ready,
  input  logic [$bits(T_RES)-1:0]               pe_res_data,
  input  logic                                  pe_res_valid,
  output logic [$bits(T_RES)-1:0]               out_res_tdata,
  output logic                                  out_res_tvalid,
  input  logic                                  out_res_tready,
  output logic [cnt_width(MAX_OUTSTANDING)-1:0] outstanding_o,
  output logic [31:0]                           jobs_done_o,
  output logic                                  overflow_o
);

  localparam int unsigned CW = cnt_width(MAX_OUTSTANDING);
  localparam int unsigned JW = $bits(T_JOB);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_OUTSTANDING);

  logic          r_job_full;
  logic [JW-1:0] r_job_data;
  logic [CW-1:0] r_outstanding;
  logic [31:0]   r_jobs_done;
  logic          r_overflow;

  logic          w_fill;
  logic          w_issue;
  logic          w_deq;
  logic          w_fifo_empty;
  logic [CW-1:0] w_fifo_count;

  assign pe_job_valid = r_job_full && (r_outstanding < MAX_C);
  assign pe_job_data  = r_job_data;
  assign w_issue      = pe_job_valid && pe_job_ready;

  // With REG_VERSION=1 tready depends only on the job register, which keeps
  // out_res_tready (via the credit count) out of the tready cone.
  assign in_job_tready = !r_job_full || ((REG_VERSION == 0) && w_issue);
  assign w_fill        = in_job_tvalid && in_job_tready;

  assign out_res_tvalid = !w_fifo_empty;
  assign w_deq          = out_res_tvalid && out_res_tready;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_job_full <= 1'b0;
      r_job_data <= '0;
    end else if (w_fill) begin
      // Covers the simultaneous issue+reload case: register stays full.
      r_job_full <= 1'b1;
      r_job_data <= in_job_tdata;
    end else if (w_issue) begin
      r_job_full <= 1'b0;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_outstanding <= '0;
      r_jobs_done   <= '0;
      r_overflow    <= 1'b0;
    end else begin
      case ({w_issue, w_deq})
        2'b10:   r_outstanding <= r_outstanding + 1'b1;
        2'b01:   r_outstanding <= r_outstanding - 1'b1;
        default: r_outstanding <= r_outstanding;
      endcase
      if (w_deq) r_jobs_done <= r_jobs_done + 32'd1;
      if (pe_res_valid && (w_fifo_count == MAX_C) && !w_deq)
        r_overflow <= ERR_OVERFLOW;
    end
  end

  cl_conveyer_tap_fifo #(
    .T_RES (T_RES),
    .DEPTH (MAX_OUTSTANDING)
  ) u_fifo (
    .clock_i   (clock_i),
    .reset_i   (reset_i),
    .i_wr      (pe_res_valid),
    .i_wr_data (pe_res_data),
    .i_rd      (w_deq),
    .o_rd_data (out_res_tdata),
    .o_empty   (w_fifo_empty),
    .o_count   (w_fifo_count)
  );

  assign outstanding_o = r_outstanding;
  assign jobs_done_o   = r_jobs_done;
  assign overflow_o    = r_overflow;

endmodule

// File: tb/tb_cl_conveyer_tap.sv
module tb_cl_conveyer_tap;

  localparam int MAXO = 2;
  localparam int MAXB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance: MAX_OUTSTANDING=2, REG_VERSION=1
  logic       reset_i        = 1'b1;
  logic [7:0] in_job_tdata   = '0;
  logic       in_job_tvalid  = 1'b0;
  logic       in_job_tready;
  logic [7:0] pe_job_data;
  logic       pe_job_valid;
  logic       pe_job_ready   = 1'b0;
  logic [7:0] pe_res_data    = '0;
  logic       pe_res_valid   = 1'b0;
  logic [7:0] out_res_tdata;
  logic       out_res_tvalid;
  logic       out_res_tready = 1'b0;
  logic [1:0] outstanding_o;
  logic [31:0] jobs_done_o;
  logic       overflow_o;

  // Second instance: MAX_OUTSTANDING=4, REG_VERSION=0
  logic [7:0] b_in_tdata     = '0;
  logic       b_in_tvalid    = 1'b0;
  logic       b_in_tready;
  logic [7:0] b_pe_data;
  logic       b_pe_valid;
  logic       b_pe_ready     = 1'b0;
  logic [7:0] b_pe_res_data  = '0;
  logic       b_pe_res_valid = 1'b0;
  logic [7:0] b_out_data;
  logic       b_out_valid;
  logic       b_out_ready    = 1'b0;
  logic [2:0] b_outstanding;
  logic [31:0] b_jobs_done;
  logic       b_overflow;

  cl_conveyer_tap #(.MAX_OUTSTANDING(MAXO), .REG_VERSION(1)) u_dut (
    .clock_i(clk), .reset_i(reset_i),
    .in_job_tdata(in_job_tdata), .in_job_tvalid(in_job_tvalid), .in_job_tready(in_job_tready),
    .pe_job_data(pe_job_data), .pe_job_valid(pe_job_valid), .pe_job_ready(pe_job_ready),
    .pe_res_data(pe_res_data), .pe_res_valid(pe_res_valid),
    .out_res_tdata(out_res_tdata), .out_res_tvalid(out_res_tvalid), .out_res_tready(out_res_tready),
    .outstanding_o(outstanding_o), .jobs_done_o(jobs_done_o), .overflow_o(overflow_o)
  );

  cl_conveyer_tap #(.MAX_OUTSTANDING(MAXB), .REG_VERSION(0)) u_dut_r0 (
    .clock_i(clk), .reset_i(reset_i),
    .in_job_tdata(b_in_tdata), .in_job_tvalid(b_in_tvalid), .in_job_tready(b_in_tready),
    .pe_job_data(b_pe_data), .pe_job_valid(b_pe_valid), .pe_job_ready(b_pe_ready),
    .pe_res_data(b_pe_res_data), .pe_res_valid(b_pe_res_valid),
    .out_res_tdata(b_out_data), .out_res_tvalid(b_out_valid), .out_res_tready(b_out_ready),
    .outstanding_o(b_outstanding), .jobs_done_o(b_jobs_done), .overflow_o(b_overflow)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Stimulus knobs
  int unsigned cyc = 0;
  bit          rst = 1'b1;
  bit          feed_en = 1'b0;
  bit          force_res = 1'b0;
  logic [7:0]  force_data = '0;
  int unsigned p_tvalid = 0, p_pe = 0, p_out = 0;
  int unsigned lat_min = 1, lat_max = 1;
  logic [7:0]  pe_xor = '0;

  // Reference model: PE pipeline, job register contents, FIFO contents,
  // end-to-end expected results, and counters.
  typedef struct { int unsigned due; logic [7:0] d; } pe_ev_t;
  pe_ev_t      pe_q[$];
  int unsigned pe_last_due = 0;
  logic [7:0]  src_q[$], job_q[$], fifo_m[$], exp_q[$], delivered[$];
  int          m_out = 0;
  int unsigned m_done = 0;
  bit          m_ovf = 1'b0;
  int unsigned n_acc = 0, n_iss = 0, first_acc = 0, last_acc = 0;

  bit          b_en = 1'b0, b_chk = 1'b0, b_iss_prev = 1'b0;
  logic [7:0]  b_src = '0, b_exp = '0, b_job_prev = '0;

  task automatic cycle();
    bit acc, iss, deq, b_acc, b_iss, b_deq;
    int unsigned due;
    pe_ev_t ev;
    reset_i        = rst;
    in_job_tvalid  = feed_en && (src_q.size() != 0) && ($urandom_range(99) < p_tvalid);
    in_job_tdata   = (src_q.size() != 0) ? src_q[0] : 8'h00;
    pe_job_ready   = ($urandom_range(99) < p_pe);
    out_res_tready = ($urandom_range(99) < p_out);
    pe_res_valid   = 1'b0;
    pe_res_data    = 8'h00;
    if (force_res) begin
      pe_res_valid = 1'b1;
      pe_res_data  = force_data;
    end else if (pe_q.size() != 0 && pe_q[0].due <= cyc) begin
      ev = pe_q.pop_front();
      pe_res_valid = 1'b1;
      pe_res_data  = ev.d;
    end
    b_in_tvalid    = b_en;
    b_in_tdata     = b_src;
    b_pe_ready     = 1'b1;
    b_out_ready    = 1'b1;
    b_pe_res_valid = b_iss_prev;
    b_pe_res_data  = b_job_prev;
    #1;
    acc   = in_job_tvalid && in_job_tready;
    iss   = pe_job_valid && pe_job_ready;
    deq   = out_res_tvalid && out_res_tready;
    b_acc = b_in_tvalid && b_in_tready;
    b_iss = b_pe_valid && b_pe_ready;
    b_deq = b_out_valid && b_out_ready;
    if (rst) begin
      pe_q.delete(); job_q.delete(); fifo_m.delete(); exp_q.delete();
      m_out = 0; m_done = 0; m_ovf = 1'b0; pe_last_due = 0;
      b_iss_prev = 1'b0; b_src = '0; b_exp = '0; b_job_prev = '0;
    end else begin
      if (deq) begin
        if (fifo_m.size() == 0) check("deq_from_empty", 1, 0);
        else check("fifo_order", out_res_tdata, fifo_m.pop_front());
        if (exp_q.size() == 0) check("e2e_unexpected", 1, 0);
        else check("e2e_result", out_res_tdata, exp_q.pop_front());
        delivered.push_back(out_res_tdata);
        m_done++;
        m_out--;
      end
      if (pe_res_valid) begin
        if (fifo_m.size() < MAXO) fifo_m.push_back(pe_res_data);
        else m_ovf = 1'b1;
      end
      if (iss) begin
        if (job_q.size() == 0) check("issue_without_job", 1, 0);
        else check("pe_job_data", pe_job_data, job_q.pop_front());
        due = cyc + $urandom_range(lat_max, lat_min);
        if (due <= pe_last_due) due = pe_last_due + 1;
        pe_last_due = due;
        ev.due = due;
        ev.d   = pe_job_data ^ pe_xor;
        pe_q.push_back(ev);
        m_out++;
        n_iss++;
      end
      if (acc) begin
        if (n_acc == 0) first_acc = cyc;
        last_acc = cyc;
        n_acc++;
        exp_q.push_back(src_q[0] ^ pe_xor);
        job_q.push_back(src_q.pop_front());
      end
      if (b_deq) begin
        check("b_result", b_out_data, b_exp);
        b_exp++;
      end
      if (b_chk) begin
        check("b_tready", b_in_tready, 1);
        check("b_issue", b_iss, 1);
        check("b_outst_le_max", b_outstanding <= 3'(MAXB), 1);
      end
      if (b_acc) b_src++;
      b_iss_prev = b_iss;
      b_job_prev = b_pe_data;
    end
    @(posedge clk);
    #1;
    check("outstanding", outstanding_o, m_out);
    check("outst_le_max", outstanding_o <= 2'(MAXO), 1);
    check("jobs_done", jobs_done_o, m_done);
    check("overflow", overflow_o, m_ovf);
    check("out_tvalid", out_res_tvalid, fifo_m.size() != 0);
    if (fifo_m.size() != 0) check("out_head", out_res_tdata, fifo_m[0]);
    check("pe_job_valid", pe_job_valid, (job_q.size() != 0) && (m_out < MAXO));
    check("in_job_tready", in_job_tready, job_q.size() == 0);
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    src_q.delete();
    delivered.delete();
    n_acc = 0;
    n_iss = 0;
  endtask

  initial begin
    // Reset state
    repeat (3) cycle();
    rst = 1'b0;
    check("rst_tready", in_job_tready, 1);
    check("rst_pe_valid", pe_job_valid, 0);
    check("rst_out_tvalid", out_res_tvalid, 0);
    check("rst_outst", outstanding_o, 0);
    check("rst_done", jobs_done_o, 0);
    check("rst_ovf", overflow_o, 0);

    // 1: credit starvation with output stalled
    src_q = '{8'h11, 8'h22, 8'h33};
    feed_en = 1'b1; p_tvalid = 100; p_pe = 100; p_out = 0;
    lat_min = 3; lat_max = 3; pe_xor = 8'h00;
    repeat (12) cycle();
    check("s1_hold_valid", pe_job_valid, 0);
    check("s1_outst", outstanding_o, 2);
    check("s1_reg_full", in_job_tready, 0);
    check("s1_head", out_res_tdata, 8'h11);
    check("s1_issued", n_iss, 2);
    p_out = 100;
    for (int k = 0; k < 40 && m_done < 3; k++) cycle();
    check("s1_done", jobs_done_o, 3);
    check("s1_issued_all", n_iss, 3);
    check("s1_n_deliv", delivered.size(), 3);
    if (delivered.size() == 3) begin
      check("s1_d0", delivered[0], 8'h11);
      check("s1_d1", delivered[1], 8'h22);
      check("s1_d2", delivered[2], 8'h33);
    end

    // 2+3: continuous streaming, REG_VERSION=0 (b) and REG_VERSION=1 (main)
    do_reset();
    for (int i = 0; i < 20; i++) src_q.push_back(8'(i + 1));
    p_tvalid = 100; p_pe = 100; p_out = 100; lat_min = 1; lat_max = 1;
    b_en = 1'b1;
    cycle();
    b_chk = 1'b1;
    repeat (25) cycle();
    b_chk = 1'b0;
    b_en = 1'b0;
    for (int k = 0; k < 80 && (src_q.size() != 0 || m_done < 20); k++) cycle();
    repeat (4) cycle();
    check("s3_accepts", n_acc, 20);
    check("s3_span", last_acc - first_acc, 38);
    check("s3_done", jobs_done_o, 20);
    check("s2_accepts", b_src, 26);
    check("s2_drained", b_exp, 26);
    check("s2_done", b_jobs_done, 26);
    check("s2_ovf", b_overflow, 0);

    // 4: simultaneous read/write on a full FIFO, then a genuine overflow
    do_reset();
    src_q = '{8'h40, 8'h41};
    p_tvalid = 100; p_pe = 100; p_out = 0; lat_min = 1; lat_max = 1; pe_xor = 8'h00;
    repeat (10) cycle();
    check("s4_full_outst", outstanding_o, 2);
    check("s4_full_valid", out_res_tvalid, 1);
    p_out = 100; force_res = 1'b1; force_data = 8'h5A;
    cycle();
    force_res = 1'b0; p_out = 0;
    check("s4_no_ovf", overflow_o, 0);
    check("s4_head_after", out_res_tdata, 8'h41);
    p_out = 100;
    cycle();
    p_out = 0;
    check("s4_kept_data", out_res_tdata, 8'h5A);
    force_res = 1'b1; force_data = 8'h66;
    cycle();
    force_data = 8'hEE;
    cycle();
    force_res = 1'b0;
    check("s4_ovf", overflow_o, 1);
    p_pe = 0;
    src_q.push_back(8'h77);
    repeat (5) cycle();
    check("s4_ovf_hold", overflow_o, 1);
    check("s4_job_waiting", pe_job_valid, 1);

    // 5: reset mid-operation
    do_reset();
    src_q = '{8'h51, 8'h52, 8'h53, 8'h54};
    p_tvalid = 100; p_pe = 100; p_out = 0; lat_min = 1; lat_max = 1;
    repeat (10) cycle();
    p_out = 100;
    cycle();
    p_out = 0;
    repeat (10) cycle();
    check("s5_pre_outst", outstanding_o, 2);
    check("s5_pre_done", jobs_done_o, 1);
    check("s5_pre_reg", in_job_tready, 0);
    check("s5_pre_tvalid", out_res_tvalid, 1);
    do_reset();
    check("s5_outst", outstanding_o, 0);
    check("s5_tvalid", out_res_tvalid, 0);
    check("s5_tready", in_job_tready, 1);
    check("s5_done", jobs_done_o, 0);
    check("s5_pe_valid", pe_job_valid, 0);
    check("s5_ovf", overflow_o, 0);

    // 6: random traffic
    do_reset();
    for (int i = 0; i < 10000; i++) src_q.push_back(8'($urandom));
    p_tvalid = 80; p_pe = 80; p_out = 80; lat_min = 1; lat_max = 3; pe_xor = 8'h3C;
    for (int k = 0; k < 80000 && m_done < 10000; k++) cycle();
    check("s6_done", jobs_done_o, 10000);
    check("s6_ovf", overflow_o, 0);
    check("s6_outst", outstanding_o, 0);
    check("s6_exp_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/cl_conveyer_tap.md
Name: cl_conveyer_tap

Overview:
Worker-side end of a conveyer chain. Pulls jobs off the last conveyer stage's output stream, issues them to one processing element (PE), and pushes the PE's results back into a result conveyer through an internal FIFO. The PE result interface has no backpressure, so flow control is credit-based: a job is issued only when FIFO space for its result is guaranteed.

Parameters:
T_JOB, logic[7:0], job payload type (same type as the feeding conveyer).
T_RES, logic[7:0], result payload type.
MAX_OUTSTANDING, 2, max jobs issued but whose result has not left the FIFO; also the FIFO depth; range 1..16.
REG_VERSION, 1, 1: in_job_tready = job register empty only; 0: also ready when the register drains this cycle.

Ports:
clock_i  in  1  clock.
reset_i  in  1  synchronous, active-high reset.
in_job_tdata  in  $bits(T_JOB)  job from conveyer.
in_job_tvalid  in  1  job valid.
in_job_tready  out  1  tap accepts job.
pe_job_data  out  $bits(T_JOB)  job to PE.
pe_job_valid  out  1  job offered to PE.
pe_job_ready  in  1  PE accepts job.
pe_res_data  in  $bits(T_RES)  PE result.
pe_res_valid  in  1  one-cycle result strobe, no ready.
out_res_tdata  out  $bits(T_RES)  result to conveyer.
out_res_tvalid  out  1  result valid.
out_res_tready  in  1  conveyer accepts result.
outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  current credit usage.
jobs_done_o  out  32  results delivered downstream.
overflow_o  out  1  sticky error: result strobe with FIFO full.

Behaviour:
- Reset: job reg empty, FIFO empty, outstanding 0, jobs_done 0, overflow 0. Outputs: in_job_tready=1, pe_job_valid=0, out_res_tvalid=0.
- Job register: fill = in_job_tvalid && in_job_tready. in_job_tready = reg_empty (REG_VERSION=1) or reg_empty || issue (REG_VERSION=0). Fill and issue in the same cycle (REG_VERSION=0) reloads the register and leaves it full.
- pe_job_valid = !reg_empty && (outstanding < MAX_OUTSTANDING). Credit-starved jobs wait in the register. Minimum latency from input to pe_job_valid is 1 cycle.
- issue = pe_job_valid && pe_job_ready. Issue increments outstanding.
- Result FIFO: pe_res_valid writes one entry. out_res_tvalid = !fifo_empty, and out_res_tdata is the head entry. The output is first-word-fall-through: a result is visible the cycle after its strobe.
- Dequeue = out_res_tvalid && out_res_tready. Dequeue decrements outstanding and increments jobs_done.
- Issue and dequeue in the same cycle: outstanding is unchanged.
- Write and read in the same cycle with the FIFO full: the read frees the slot, the write is accepted, and no overflow is flagged.
- pe_res_valid with FIFO full and no dequeue: result dropped, overflow_o set and held until reset. This is a PE protocol violation and is unreachable with a compliant PE.
- Pointers wrap modulo MAX_OUTSTANDING. Full/empty is tracked with a count, not pointer equality.
- jobs_done_o wraps at 2^32.
- Reset mid-operation discards the job register and FIFO contents. The PE must be reset by the same reset.
- No combinational path from out_res_tready to in_job_tready when REG_VERSION=1.

Decomposition:
- Package cl_conveyer_pkg: function for counter width, ERR_OVERFLOW constant. The T_JOB/T_RES defaults stay in the module parameters.
- Sub-module cl_conveyer_tap_fifo: parameterised-depth FWFT FIFO of T_RES with count output. The credit logic and job register stay in the top module.

Test Plan:
1. MAX_OUTSTANDING=2; push jobs 0x11, 0x22, 0x33 with out_res_tready=0 and the PE echoing each result 3 cycles after issue -> 0x11 and 0x22 issued; 0x33 held with pe_job_valid=0 and outstanding_o=2. Assert out_res_tready -> results 0x11, 0x22 delivered in order, then 0x33 issued; jobs_done_o=3.
2. Continuous jobs with always-ready PE, 1-cycle echo, REG_VERSION=0 -> one job per cycle, and in_job_tready never drops after the first fill.
3. Same as scenario 2 with REG_VERSION=1 -> one job every 2 cycles.
4. FIFO full, out_res_tready=1 and pe_res_valid=1 in the same cycle -> no overflow and no data loss. Then force a result strobe with the FIFO full and no dequeue -> overflow_o=1, held across subsequent traffic.
5. Assert reset with 2 results queued and a job in the register -> next cycle outstanding_o=0, out_res_tvalid=0, in_job_tready=1, jobs_done_o=0.
6. Random tvalid/tready/PE latency over 10k jobs -> the output sequence equals the input sequence mapped by the PE, outstanding_o never exceeds MAX_OUTSTANDING, and overflow_o stays 0.
